// File: rtl/interval_meter_pkg.sv
// interval_meter_pkg: shared FSM state encoding and saturation constant helper.
package interval_meter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    function automatic longint unsigned sat_of(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/interval_meter_rise_detect.sv
// rise_detect: one-cycle rising-edge strobe; resets high so a level already high at release is not an edge.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_q <= 1'b1;
        else          r_q <= i_d;

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/interval_meter.sv
// interval_meter: counts CLK cycles from a START rising edge to the next STOP rising edge, saturating,
// and holds each result on a VALID/ACK handshake.
module interval_meter
    import interval_meter_pkg::*;
#(
    parameter int BIT = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_stop,
    input  logic           i_ack,
    output logic           o_busy,
    output logic           o_valid,
    output logic [BIT-1:0] o_result,
    output logic           o_ovf,
    output logic           o_drop
);

    localparam logic [BIT-1:0] SAT = BIT'(sat_of(BIT));

    state_t         r_state, w_next;
    logic [BIT-1:0] r_cnt, r_result, w_cnt_inc;
    logic           r_sat, r_ovf, r_valid, r_drop;
    logic           w_start_e, w_stop_e;
    logic           w_load, w_inc, w_capture, w_release, w_drop;

    rise_detect u_start (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_start),
        .o_rise (w_start_e)
    );

    rise_detect u_stop (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_stop),
        .o_rise (w_stop_e)
    );

    assign w_cnt_inc = (r_cnt == SAT) ? SAT : r_cnt + BIT'(1);

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = w_start_e ? RUN : IDLE;
                w_load = w_start_e;
            end
            // STOP has priority over a coincident restart
            RUN: begin
                w_next    = w_stop_e ? HOLD : RUN;
                w_capture = w_stop_e;
                w_load    = ~w_stop_e & w_start_e;
                w_inc     = ~w_stop_e & ~w_start_e;
            end
            HOLD: begin
                w_next    = i_ack ? (w_start_e ? RUN : IDLE) : HOLD;
                w_release = i_ack;
                w_load    = i_ack & w_start_e;
                w_drop    = ~i_ack & w_start_e;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drop  <= w_drop;
            if (w_load) begin
                r_cnt <= BIT'(1);
                r_sat <= 1'b0;
            end else if (w_inc) begin
                r_cnt <= w_cnt_inc;
                r_sat <= (w_cnt_inc == SAT);
            end
            if (w_capture) begin
                r_result <= r_cnt;
                r_ovf    <= r_sat;
                r_valid  <= 1'b1;
            end else if (w_release) begin
                r_valid <= 1'b0;
            end
        end

    assign o_busy   = (r_state == RUN);
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_ovf    = r_ovf;
    assign o_drop   = r_drop;

endmodule

// File: tb/tb_interval_meter.sv
// tb_interval_meter: drives BIT=8 and BIT=4 instances with shared stimulus and checks both
// against an interval-arithmetic reference model.
module tb_interval_meter;

    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0;
    logic       busy8, valid8, ovf8, drop8, busy4, valid4, ovf4, drop4;
    logic [7:0] res8;
    logic [3:0] res4;

    interval_meter #(.BIT(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_ack(ack),
        .o_busy(busy8), .o_valid(valid8), .o_result(res8), .o_ovf(ovf8), .o_drop(drop8)
    );

    interval_meter #(.BIT(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_ack(ack),
        .o_busy(busy4), .o_valid(valid4), .o_result(res4), .o_ovf(ovf4), .o_drop(drop4)
    );

    always #5 clk = ~clk;

    int    n_assert = 0, n_fail = 0;
    int    m_mode, m_t0, m_cyc, m_k, m_r8, m_r4;
    bit    m_valid, m_drop, m_ps, m_pp, m_o8, m_o4;
    string phase = "init";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_valid = 1'b0;
        m_drop  = 1'b0;
        m_ps    = 1'b1;
        m_pp    = 1'b1;
        m_r8    = 0;
        m_r4    = 0;
        m_o8    = 1'b0;
        m_o4    = 1'b0;
    endtask

    // Result is simply the cycle distance between the opening and closing edges, clamped.
    task automatic model_clock(input bit s, input bit p, input bit a);
        bit se, pe;
        se = s & ~m_ps;
        pe = p & ~m_pp;
        m_ps = s;
        m_pp = p;
        m_cyc++;
        m_drop = 1'b0;
        if (m_mode == M_IDLE) begin
            if (se) begin m_mode = M_RUN; m_t0 = m_cyc; end
        end else if (m_mode == M_RUN) begin
            if (pe) begin
                m_k     = m_cyc - m_t0;
                m_r8    = (m_k > 255) ? 255 : m_k;
                m_o8    = (m_k >= 255);
                m_r4    = (m_k > 15) ? 15 : m_k;
                m_o4    = (m_k >= 15);
                m_valid = 1'b1;
                m_mode  = M_HOLD;
            end else if (se) m_t0 = m_cyc;
        end else begin
            if (a) begin
                m_valid = 1'b0;
                m_mode  = se ? M_RUN : M_IDLE;
                m_t0    = m_cyc;
            end else m_drop = se;
        end
    endtask

    task automatic check_all();
        chk("busy8", busy8, m_mode == M_RUN);
        chk("busy4", busy4, m_mode == M_RUN);
        chk("valid8", valid8, m_valid);
        chk("valid4", valid4, m_valid);
        chk("drop8", drop8, m_drop);
        chk("drop4", drop4, m_drop);
        chk("result8", res8, m_r8);
        chk("ovf8", ovf8, m_o8);
        chk("result4", res4, m_r4);
        chk("ovf4", ovf4, m_o4);
    endtask

    task automatic step(input bit s, input bit p, input bit a);
        start = s;
        stop  = p;
        ack   = a;
        @(posedge clk);
        model_clock(s, p, a);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input bit s, input bit p, input bit a, input int n);
        repeat (n) step(s, p, a);
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("rst_busy", busy8, 1'b0);
        chk("rst_valid", valid8, 1'b0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        m_cyc = 0;
        m_t0  = 0;
        phase = "reset";
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        run(0, 0, 0, 3);

        phase = "basic25";
        run(0, 0, 0, 5);
        step(1, 0, 0);
        run(1, 0, 0, 24);
        step(1, 1, 0);
        chk("r25", res8, 25);
        chk("v25", valid8, 1'b1);
        run(0, 0, 0, 2);
        step(0, 0, 1);
        chk("v_after_ack", valid8, 1'b0);
        run(0, 0, 0, 2);

        phase = "saturate";
        step(1, 0, 0);
        run(0, 0, 0, 39);
        step(0, 1, 0);
        chk("r40_8", res8, 40);
        chk("o40_8", ovf8, 1'b0);
        chk("r40_4", res4, 15);
        chk("o40_4", ovf4, 1'b1);
        step(0, 0, 1);
        step(1, 0, 0);
        run(0, 0, 0, 2);
        step(0, 1, 0);
        chk("r3_4", res4, 3);
        chk("o3_4", ovf4, 1'b0);
        step(0, 0, 1);

        phase = "restart";
        step(1, 0, 0);
        run(0, 0, 0, 4);
        step(1, 0, 0);
        run(0, 0, 0, 6);
        step(0, 1, 0);
        chk("r7", res8, 7);
        step(0, 0, 1);

        phase = "drop";
        step(1, 0, 0);
        run(0, 0, 0, 2);
        step(0, 1, 0);
        step(1, 0, 0);
        chk("drop_hi", drop8, 1'b1);
        step(0, 0, 0);
        chk("drop_lo", drop8, 1'b0);
        chk("r_held", res8, 3);
        step(1, 0, 1);
        chk("ack_start_busy", busy8, 1'b1);
        run(0, 0, 0, 3);
        step(0, 1, 0);
        chk("r4", res8, 4);
        step(0, 0, 1);

        phase = "tied";
        step(1, 1, 0);
        chk("tied_busy", busy8, 1'b1);
        run(0, 0, 0, 19);
        step(1, 1, 0);
        chk("r20", res8, 20);
        step(0, 0, 1);

        phase = "async_rst";
        step(1, 0, 0);
        run(1, 0, 0, 3);
        pulse_reset();
        run(1, 0, 0, 5);
        chk("held_start_idle", busy8, 1'b0);
        step(0, 0, 0);
        step(1, 0, 0);
        run(0, 0, 0, 2);
        step(0, 1, 0);
        step(0, 0, 0);
        pulse_reset();
        run(0, 0, 0, 2);

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
